// File: rtl/ulas_pkg.sv
// Shared ULAS definitions: ALU opcodes and multiply/divide sequencer types.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package ulas_pkg;

    // ULAS aluop encodings
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00011;
    localparam logic [4:0] ALU_OR   = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b00101;
    localparam logic [4:0] ALU_SLL  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_SLT  = 5'b01001;
    localparam logic [4:0] ALU_MULT = 5'b10000;
    localparam logic [4:0] ALU_DIV  = 5'b10001;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_t;

    // Datapath mode selected for the single-iteration kernel
    typedef enum logic {
        MDU_MULT = 1'b0,
        MDU_DIV  = 1'b1
    } mdu_mode_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register acc_nxt.
//
// Ports:
//   mode     - MDU_MULT or MDU_DIV
//   acc      - 2*WIDTH accumulator: mult {acc_hi, mplier}, div {remainder, dividend/quotient}
//   operand  - multiplicand (mult) or divisor (div)
//   acc_nxt  - accumulator after this iteration
// Config macro: ULAS_MDU_DIV_EN includes the restoring-subtract path.
module mdu_step
    import ulas_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_mode_t            mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_nxt
);

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mult_nxt;

    // Add is WIDTH+1 wide so the carry drops into the high word on the shift.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mult_nxt = {sum, acc[WIDTH-1:1]};
    end

`ifdef ULAS_MDU_DIV_EN
    logic [WIDTH:0]       part;
    logic [WIDTH-1:0]     diff;
    logic [2*WIDTH-1:0]   div_nxt;

    // part = remainder shifted left with the next dividend bit. The remainder
    // stays below the divisor, so a kept difference always fits in WIDTH bits
    // and the low WIDTH bits of the subtraction are exact.
    always_comb begin
        part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = part[WIDTH-1:0] - operand;
        if (part >= {1'b0, operand}) begin
            div_nxt = {diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        acc_nxt = (mode == MDU_DIV) ? div_nxt : mult_nxt;
    end
`else
    // Divide is never started in this build; hold the accumulator if asked.
    always_comb begin
        acc_nxt = (mode == MDU_DIV) ? acc : mult_nxt;
    end
`endif

endmodule

// File: rtl/ulas_mdu_seq.sv
// Multi-cycle unsigned multiply/divide sequencer beside the ULAS ALU.
// Latency: WIDTH+1 cycles from accepted start to done; error ops done next cycle.
// Backpressure: busy high while iterating; start outside IDLE is dropped, not queued.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start, aluop  - request and opcode (ALU_MULT / ALU_DIV), sampled in IDLE
//   op1, op2      - multiplicand/dividend, multiplier/divisor
//   busy          - iteration in progress
//   done          - one-cycle pulse, r1/hi/UF valid
//   r1, hi        - low word/quotient, high word/remainder (held until next done)
//   UF            - divide by zero or unsupported aluop
// Config macro: ULAS_MDU_DIV_EN enables the divider; without it DIV reports UF.
module ulas_mdu_seq
    import ulas_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        aluop,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  r1,
    output logic [WIDTH-1:0]  hi,
    output logic              UF
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t          state_q, state_d;
    mdu_mode_t           mode_q,  mode_d;
    logic [2*WIDTH-1:0]  acc_q,   acc_d;
    logic [WIDTH-1:0]    opnd_q,  opnd_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0]    r1_q,    r1_d;
    logic [WIDTH-1:0]    hi_q,    hi_d;
    logic                uf_q,    uf_d;

    logic [2*WIDTH-1:0]  acc_nxt;

    mdu_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .mode    (mode_q),
        .acc     (acc_q),
        .operand (opnd_q),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MDU_MULT;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            r1_q    <= '0;
            hi_q    <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            r1_q    <= r1_d;
            hi_q    <= hi_d;
            uf_q    <= uf_d;
        end
    end

    // Result registers are only written on the edge that enters FIN, so
    // r1/hi/UF stay stable from one done to the next.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        r1_d    = r1_q;
        hi_d    = hi_q;
        uf_d    = uf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (aluop == ALU_MULT) begin
                        // {acc_hi, mplier} starts as {0, op2}; op1 is added in.
                        acc_d   = {{WIDTH{1'b0}}, op2};
                        opnd_d  = op1;
                        mode_d  = MDU_MULT;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
`ifdef ULAS_MDU_DIV_EN
                    else if (aluop == ALU_DIV) begin
                        if (op2 == '0) begin
                            r1_d    = '1;
                            hi_d    = op1;
                            uf_d    = 1'b1;
                            state_d = FIN;
                        end else begin
                            // {remainder, dividend}; quotient bits shift in at the bottom.
                            acc_d   = {{WIDTH{1'b0}}, op1};
                            opnd_d  = op2;
                            mode_d  = MDU_DIV;
                            cnt_d   = '0;
                            state_d = RUN;
                        end
                    end
`endif
                    else begin
                        r1_d    = '0;
                        hi_d    = '0;
                        uf_d    = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            RUN: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Take the final iteration straight from the kernel.
                    r1_d    = acc_nxt[WIDTH-1:0];
                    hi_d    = acc_nxt[2*WIDTH-1:WIDTH];
                    uf_d    = 1'b0;
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);
    assign r1   = r1_q;
    assign hi   = hi_q;
    assign UF   = uf_q;

endmodule

// File: tb/tb_ulas_mdu_seq.sv
// Bench for ulas_mdu_seq: scoreboard of expected results checked on each done.
// Latency: checks done arrives 33 cycles after a legal start, 1 after an error start.
// Backpressure: checks ignored starts (busy/FIN) produce no result.
module tb_ulas_mdu_seq;
    import ulas_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    aluop;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic          busy;
    logic          done;
    logic [W-1:0]  r1;
    logic [W-1:0]  hi;
    logic          UF;

    always #5 clk = ~clk;

    ulas_mdu_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .aluop (aluop),
        .op1   (op1),
        .op2   (op2),
        .busy  (busy),
        .done  (done),
        .r1    (r1),
        .hi    (hi),
        .UF    (UF)
    );

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] hi;
        logic         uf;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain arithmetic on the operands.
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        e.acc_cyc = 0;
        if (op == ALU_MULT) begin
            p     = {32'b0, a} * {32'b0, b};
            e.r1  = p[31:0];
            e.hi  = p[63:32];
            e.uf  = 1'b0;
            e.lat = 33;
        end
`ifdef ULAS_MDU_DIV_EN
        else if (op == ALU_DIV && b == 0) begin
            e.r1  = 32'hFFFF_FFFF;
            e.hi  = a;
            e.uf  = 1'b1;
            e.lat = 1;
        end else if (op == ALU_DIV) begin
            e.r1  = a / b;
            e.hi  = a % b;
            e.uf  = 1'b0;
            e.lat = 33;
        end
`endif
        else begin
            e.r1  = '0;
            e.hi  = '0;
            e.uf  = 1'b1;
            e.lat = 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (busy && done) check("busy_done_excl", 64'd1, 64'd0);
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("r1",  {32'b0, r1}, {32'b0, e.r1});
                check("hi",  {32'b0, hi}, {32'b0, e.hi});
                check("uf",  {63'b0, UF}, {63'b0, e.uf});
                check("lat", 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    // Called at a negedge; start is presented for exactly one cycle.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e         = model(op, a, b);
        e.acc_cyc = cyc;
        start     = 1'b1;
        aluop     = op;
        op1       = a;
        op2       = b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (e.lat == 1) check("err_no_busy", {63'b0, busy}, 64'd0);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [4:0]   rop;
        logic [W-1:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        aluop = '0;
        op1   = '0;
        op2   = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_r1",   {32'b0, r1},   64'd0);
        check("rst_hi",   {32'b0, hi},   64'd0);
        check("rst_uf",   {63'b0, UF},   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(ALU_DIV, 32'd100, 32'd7);
        drain();
        issue(ALU_DIV, 32'd5, 32'd0);
        drain();

        // Second start while busy is dropped
        issue(ALU_MULT, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        check("busy_mid", {63'b0, busy}, 64'd1);
        start = 1'b1; aluop = ALU_MULT; op1 = 32'd5; op2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-run aborts; outputs clear at once
        issue(ALU_MULT, 32'd9, 32'd9);
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_done", {63'b0, done}, 64'd0);
        check("arst_r1",   {32'b0, r1},   64'd0);
        check("arst_hi",   {32'b0, hi},   64'd0);
        check("arst_uf",   {63'b0, UF},   64'd0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(ALU_MULT, 32'd2, 32'd2);
        drain();

        // Unsupported opcode
        issue(ALU_AND, 32'd7, 32'd3);
        drain();

        // Start held through the done cycle: only the first IDLE cycle accepts
        issue(ALU_MULT, 32'd11, 32'd13);
        g = 0;
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("b2b_done_seen", {63'b0, done}, 64'd1);
        start = 1'b1; aluop = ALU_MULT; op1 = 32'd5; op2 = 32'd5;
        @(negedge clk);
        issue(ALU_MULT, 32'd6, 32'd7);
        drain();

        // Random mix of mult, div and other opcodes
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0:       rop = ALU_MULT;
                1:       rop = ALU_DIV;
                default: rop = 5'($urandom_range(1, 9));
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            issue(rop, ra, rb);
            drain();
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
